// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths, ALU codes and forward-select enum
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CNT_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CNT_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CNT_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [CNT_W-1:0] ALU_SRL = 4'b0100;
    localparam logic [CNT_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CNT_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CNT_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand forwarding select, EX/MEM over MEM/WB, r0 never forwards
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == src_addr)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data = reg_data;
        case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_result;
            default:   data = reg_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with forwarding and load-use bubble insertion
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = mips_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [CNT_W-1:0]  id_alu_cnt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_use_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0] memwb_result,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  alu_cnt,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use_hazard
);

    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [REG_AW-1:0] rs_addr_q, rt_addr_q;
    logic              use_imm_q;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              load_bubble, capture;

    always_comb begin
        load_use_hazard = id_valid && ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                          ((id_rs_addr == ex_rd_addr) || (id_rt_addr == ex_rd_addr));
        // Held low in reset so nothing upstream advances into a stage being cleared.
        id_ready    = rst_n && !stall && !flush && !load_use_hazard;
        load_bubble = !rst_n || flush || (!stall && (load_use_hazard || !id_valid));
        capture     = !load_bubble && !stall;
    end

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid     <= 1'b0;
            alu_cnt      <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            imm_q        <= '0;
            shamt        <= '0;
            use_imm_q    <= 1'b0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (capture) begin
            ex_valid     <= 1'b1;
            alu_cnt      <= id_alu_cnt;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            imm_q        <= id_imm;
            shamt        <= id_shamt;
            use_imm_q    <= id_use_imm;
            ex_rd_addr   <= id_rd_addr;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_addr        (rs_addr_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .data            (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_addr        (rt_addr_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .data            (rt_fwd)
    );

    assign input1        = rs_fwd;
    assign input2        = use_imm_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;

endmodule
